// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, functs,
// ALU and mux-select encodings, and the controller state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> IR/datapath signal bundle; master is the controller side.
interface multicycle_controller_if #(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16
);
  logic [INSTR_W-1:0]    instr;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  branch;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic                  mem_to_reg;
  logic                  reg_dst;
  logic                  reg_write;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            pc_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal;
  logic [CNT_W-1:0]      retired;

  modport master (
    input  instr, mem_ready,
    output pc_write, branch, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
           illegal, retired
  );

  modport slave (
    output instr, mem_ready,
    input  pc_write, branch, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
           illegal, retired
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALU control from controller state and R-type funct; also flags supported functs.
module mc_alu_decoder
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  state_t                i_state,
  input  logic [5:0]            i_funct,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_funct_valid
);

  logic [2:0] w_funct_alu;
  logic [2:0] w_alu;

  always_comb begin
    w_funct_alu   = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_funct)
      FN_ADD:  w_funct_alu = ALU_ADD;
      FN_SUB:  w_funct_alu = ALU_SUB;
      FN_AND:  w_funct_alu = ALU_AND;
      FN_OR:   w_funct_alu = ALU_OR;
      FN_SLT:  w_funct_alu = ALU_SLT;
      default: o_funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_alu = ALU_ADD;
    case (i_state)
      S_EXEC:   w_alu = w_funct_alu;
      S_BRANCH: w_alu = ALU_SUB;
      default:  w_alu = ALU_ADD;
    endcase
  end

  assign o_alu_control = ALU_CTRL_W'(w_alu);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/writeback,
// stalls on memory handshake, and counts retired instructions.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16,
  parameter bit MEM_HS     = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_controller_if.master  bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_mem_rdy;
  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_funct_valid;
  logic       w_retire;
  logic       w_unused_instr;

  logic       w_pc_write, w_branch, w_iord, w_mem_read, w_mem_write;
  logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic       w_illegal;
  logic [1:0] w_alu_src_b, w_pc_src;

  assign w_mem_rdy      = MEM_HS ? bus.mem_ready : 1'b1;
  assign w_opcode       = bus.instr[INSTR_W-1 -: 6];
  assign w_funct        = bus.instr[5:0];
  assign w_unused_instr = ^bus.instr[INSTR_W-7:6];

  mc_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .i_state       (r_state),
    .i_funct       (w_funct),
    .o_alu_control (bus.alu_control),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_pc_src     = PCSRC_ALU;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (w_mem_rdy) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH;
        case (w_opcode)
          OP_RTYPE: begin
            if (w_funct_valid) w_next = S_EXEC;
            else begin
              w_illegal = 1'b1;
              w_next    = S_FETCH;
            end
          end
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (w_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (w_mem_rdy) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (w_mem_rdy) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_branch    = 1'b1;
        w_pc_src    = PCSRC_ALUOUT;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = PCSRC_JUMP;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are qualified with rst_n so nothing fires while reset is held.
  assign bus.pc_write   = w_pc_write  & rst_n;
  assign bus.branch     = w_branch    & rst_n;
  assign bus.mem_read   = w_mem_read  & rst_n;
  assign bus.mem_write  = w_mem_write & rst_n;
  assign bus.ir_write   = w_ir_write  & rst_n;
  assign bus.reg_write  = w_reg_write & rst_n;
  assign bus.illegal    = w_illegal   & rst_n;
  assign bus.iord       = w_iord;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.pc_src     = w_pc_src;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors for each
// instruction class, stalls, illegal decode, async reset and counter wrap.
module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  multicycle_controller_if #(.INSTR_W(32), .ALU_CTRL_W(3), .CNT_W(16)) bus ();
  multicycle_controller_if #(.INSTR_W(32), .ALU_CTRL_W(3), .CNT_W(4))  bus_s ();

  multicycle_controller #(.INSTR_W(32), .ALU_CTRL_W(3), .CNT_W(16), .MEM_HS(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  multicycle_controller #(.INSTR_W(32), .ALU_CTRL_W(3), .CNT_W(4), .MEM_HS(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // pc_w br iord mrd mwr irw m2r rdst rw srca | srcb | pcsrc | alu | ill
  localparam logic [17:0] V_RST    = 18'b0_0_0_0_0_0_0_0_0_0_01_00_010_0;
  localparam logic [17:0] V_FETCHW = 18'b0_0_0_1_0_0_0_0_0_0_01_00_010_0;
  localparam logic [17:0] V_FETCH  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_010_0;
  localparam logic [17:0] V_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [17:0] V_ILL    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_010_1;
  localparam logic [17:0] V_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [17:0] V_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_010_0;
  localparam logic [17:0] V_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_010_0;
  localparam logic [17:0] V_MEMWR  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_010_0;
  localparam logic [17:0] V_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_010_0;
  localparam logic [17:0] V_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [17:0] V_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_010_0;
  localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_10_010_0;

  localparam logic [31:0] I_LW   = {6'b100011, 26'd0};
  localparam logic [31:0] I_SW   = {6'b101011, 26'd0};
  localparam logic [31:0] I_BEQ  = {6'b000100, 26'd0};
  localparam logic [31:0] I_ADDI = {6'b001000, 26'd0};
  localparam logic [31:0] I_J    = {6'b000010, 26'd0};
  localparam logic [31:0] I_BAD  = {6'b111111, 26'd0};
  localparam logic [31:0] I_BADF = {26'd0, 6'b000111};

  function automatic logic [17:0] v_exec(input logic [2:0] alu);
    return {10'b0000000001, 2'b00, 2'b00, alu, 1'b0};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.pc_write, bus.branch, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_control, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic set_instr(input logic [31:0] ins);
    bus.instr   = ins;
    bus_s.instr = ins;
  endtask

  task automatic set_rdy(input logic rdy);
    bus.mem_ready   = rdy;
    bus_s.mem_ready = rdy;
  endtask

  // Called just after a falling edge: drive mem_ready, check, advance one cycle.
  task automatic step(input string tag, input logic rdy, input logic [17:0] exp_v,
                      input logic [15:0] exp_r);
    set_rdy(rdy);
    #1;
    chk(tag, obs_vec(), exp_v);
    chk({tag, "_retired"}, 18'(bus.retired), 18'(exp_r));
    @(negedge clk);
  endtask

  logic [5:0]  r_functs [4];
  logic [2:0]  r_alus   [4];
  logic [15:0] ret;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    r_functs = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    r_alus   = '{3'b010, 3'b000, 3'b001, 3'b111};
    rst_n = 1'b0;
    set_instr(I_LW);
    set_rdy(1'b1);

    @(negedge clk);
    #1;
    chk("reset_outputs", obs_vec(), V_RST);
    chk("reset_retired", 18'(bus.retired), 18'd0);
    chk("reset_retired_small", 18'(bus_s.retired), 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw with a one-cycle fetch stall, then 5-cycle body
    step("lw_fetch_stall", 1'b0, V_FETCHW, 16'd0);
    step("lw_fetch", 1'b1, V_FETCH, 16'd0);
    step("lw_decode", 1'b1, V_DECODE, 16'd0);
    step("lw_memadr", 1'b1, V_MEMADR, 16'd0);
    step("lw_memrd", 1'b1, V_MEMRD, 16'd0);
    step("lw_memwb", 1'b1, V_MEMWB, 16'd0);

    // sw with three wait cycles in MEMWR
    set_instr(I_SW);
    step("sw_fetch", 1'b1, V_FETCH, 16'd1);
    step("sw_decode", 1'b1, V_DECODE, 16'd1);
    step("sw_memadr", 1'b1, V_MEMADR, 16'd1);
    step("sw_memwr_w0", 1'b0, V_MEMWR, 16'd1);
    step("sw_memwr_w1", 1'b0, V_MEMWR, 16'd1);
    step("sw_memwr_w2", 1'b0, V_MEMWR, 16'd1);
    step("sw_memwr_go", 1'b1, V_MEMWR, 16'd1);

    // R-type sub
    set_instr({26'd0, 6'b100010});
    step("sub_fetch", 1'b1, V_FETCH, 16'd2);
    step("sub_decode", 1'b1, V_DECODE, 16'd2);
    step("sub_exec", 1'b1, v_exec(3'b110), 16'd2);
    step("sub_aluwb", 1'b1, V_ALUWB, 16'd2);

    ret = 16'd3;
    for (int i = 0; i < 4; i++) begin
      set_instr({26'd0, r_functs[i]});
      step("rt_fetch", 1'b1, V_FETCH, ret);
      step("rt_decode", 1'b1, V_DECODE, ret);
      step($sformatf("rt_exec_f%b", r_functs[i]), 1'b1, v_exec(r_alus[i]), ret);
      step("rt_aluwb", 1'b1, V_ALUWB, ret);
      ret = ret + 16'd1;
    end

    set_instr(I_BEQ);
    step("beq_fetch", 1'b1, V_FETCH, 16'd7);
    step("beq_decode", 1'b1, V_DECODE, 16'd7);
    step("beq_branch", 1'b1, V_BRANCH, 16'd7);

    set_instr(I_ADDI);
    step("addi_fetch", 1'b1, V_FETCH, 16'd8);
    step("addi_decode", 1'b1, V_DECODE, 16'd8);
    step("addi_ex", 1'b1, V_MEMADR, 16'd8);
    step("addi_wb", 1'b1, V_ADDIWB, 16'd8);

    set_instr(I_J);
    step("j_fetch", 1'b1, V_FETCH, 16'd9);
    step("j_decode", 1'b1, V_DECODE, 16'd9);
    step("j_jump", 1'b1, V_JUMP, 16'd9);

    // illegal opcode and illegal R-type funct: no retirement
    set_instr(I_BAD);
    step("badop_fetch", 1'b1, V_FETCH, 16'd10);
    step("badop_decode", 1'b1, V_ILL, 16'd10);
    set_instr(I_BADF);
    step("badfn_fetch", 1'b1, V_FETCH, 16'd10);
    step("badfn_decode", 1'b1, V_ILL, 16'd10);
    set_instr(I_J);
    step("after_ill_fetch", 1'b1, V_FETCH, 16'd10);
    step("after_ill_decode", 1'b1, V_DECODE, 16'd10);
    step("after_ill_jump", 1'b1, V_JUMP, 16'd10);

    // async reset in the middle of a stalled store
    set_instr(I_SW);
    step("rsw_fetch", 1'b1, V_FETCH, 16'd11);
    step("rsw_decode", 1'b1, V_DECODE, 16'd11);
    step("rsw_memadr", 1'b1, V_MEMADR, 16'd11);
    set_rdy(1'b0);
    #1;
    chk("rsw_memwr", obs_vec(), V_MEMWR);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", obs_vec(), V_RST);
    chk("async_rst_retired", 18'(bus.retired), 18'd0);
    chk("async_rst_retired_small", 18'(bus_s.retired), 18'd0);
    @(negedge clk);
    #1;
    chk("rst_held_outputs", obs_vec(), V_RST);
    @(negedge clk);
    rst_n = 1'b1;

    // 16 jumps: 4-bit counter wraps back to 0
    set_instr(I_J);
    for (int i = 0; i < 16; i++) begin
      step("wrap_fetch", 1'b1, V_FETCH, 16'(i));
      step("wrap_decode", 1'b1, V_DECODE, 16'(i));
      if (i == 15) chk("wrap_small_15", 18'(bus_s.retired), 18'd15);
      step("wrap_jump", 1'b1, V_JUMP, 16'(i));
    end
    #1;
    chk("wrap_retired_main", 18'(bus.retired), 18'd16);
    chk("wrap_retired_small", 18'(bus_s.retired), 18'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
